// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and types for the fetch PC generator: opcodes, widths, fetch FSM states.
package fetch_pc_gen_pkg;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned BHT_LR_WIDTH = 8;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle: i-cache request/response, BHT lookup, instruction-queue push, ROB flush, global enable.
interface fetch_pc_gen_if #(
  parameter int unsigned ADDR_W    = fetch_pc_gen_pkg::ADDR_W,
  parameter int unsigned BHT_IDX_W = fetch_pc_gen_pkg::BHT_LR_WIDTH
);
  logic                 rdy;
  logic                 fetch_req;
  logic [ADDR_W-1:0]    fetch_addr;
  logic                 fetch_valid;
  logic [31:0]          fetch_inst;
  logic [BHT_IDX_W-1:0] bht_id;
  logic                 bht_get;
  logic                 iq_full;
  logic                 iq_push;
  logic [31:0]          iq_inst;
  logic [ADDR_W-1:0]    iq_pc;
  logic                 iq_pred_taken;
  logic [ADDR_W-1:0]    iq_pred_pc;
  logic [BHT_IDX_W-1:0] iq_bht_idx;
  logic                 flush;
  logic [ADDR_W-1:0]    flush_pc;

  modport master (
    input  rdy, fetch_valid, fetch_inst, bht_get, iq_full, flush, flush_pc,
    output fetch_req, fetch_addr, bht_id, iq_push, iq_inst, iq_pc,
           iq_pred_taken, iq_pred_pc, iq_bht_idx
  );

  modport slave (
    output rdy, fetch_valid, fetch_inst, bht_get, iq_full, flush, flush_pc,
    input  fetch_req, fetch_addr, bht_id, iq_push, iq_inst, iq_pc,
           iq_pred_taken, iq_pred_pc, iq_bht_idx
  );
endinterface

// File: rtl/fetch_pc_gen_branch_predecode.sv
// Combinational predecode of one fetched word: direction guess and predicted next PC.
module fetch_pc_gen_branch_predecode #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [31:0]       i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_bht_get,
  output logic              o_taken,
  output logic [ADDR_W-1:0] o_pred_pc
);
  import fetch_pc_gen_pkg::*;

  logic [12:0]       w_imm_b;
  logic [20:0]       w_imm_j;
  logic [ADDR_W-1:0] w_off_b;
  logic [ADDR_W-1:0] w_off_j;

  assign w_imm_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_off_b = {{(ADDR_W-13){w_imm_b[12]}}, w_imm_b};
  assign w_off_j = {{(ADDR_W-21){w_imm_j[20]}}, w_imm_j};

  // JALR target depends on a register value, so it is predicted as fall-through.
  always_comb begin
    o_taken   = 1'b0;
    o_pred_pc = i_pc + ADDR_W'(4);
    case (i_inst[6:0])
      OPC_BRANCH: begin
        if (i_bht_get) begin
          o_taken   = 1'b1;
          o_pred_pc = i_pc + w_off_b;
        end
      end
      OPC_JAL: begin
        o_taken   = 1'b1;
        o_pred_pc = i_pc + w_off_j;
      end
      OPC_JALR: begin
        o_taken   = 1'b0;
        o_pred_pc = i_pc + ADDR_W'(4);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: one i-cache request per instruction, predecode, push to the
// instruction queue and redirect to the predicted PC; ROB flushes restart at flush_pc.
module fetch_pc_gen #(
  parameter int unsigned       ADDR_W    = fetch_pc_gen_pkg::ADDR_W,
  parameter int unsigned       BHT_IDX_W = fetch_pc_gen_pkg::BHT_LR_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic             clk,
  input logic             rst,
  fetch_pc_gen_if.master  bus
);
  import fetch_pc_gen_pkg::*;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nx;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nx;
  logic [ADDR_W-1:0] r_hold_pc;
  logic [31:0]       r_inst;
  logic              r_hold_valid;
  logic              r_last_taken;
  logic [ADDR_W-1:0] r_last_pred_pc;
  logic              w_taken;
  logic [ADDR_W-1:0] w_pred_pc;
  logic              w_in_hold;
  logic              w_latch;
  logic              w_push;
  logic              w_fetch_req;

  fetch_pc_gen_branch_predecode #(.ADDR_W(ADDR_W)) u_predecode (
    .i_inst    (r_inst),
    .i_pc      (r_hold_pc),
    .i_bht_get (bus.bht_get),
    .o_taken   (w_taken),
    .o_pred_pc (w_pred_pc)
  );

  assign w_in_hold = (r_state == ST_HOLD);

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_fetch_req = 1'b0;
    if (bus.rdy && !rst) begin
      case (r_state)
        ST_REQ: begin
          w_fetch_req = 1'b1;
          w_state_nx  = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.fetch_valid) begin
            w_latch    = 1'b1;
            w_state_nx = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_hold_valid && !bus.iq_full) begin
            w_push     = 1'b1;
            w_pc_nx    = w_pred_pc;
            w_state_nx = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (bus.fetch_valid) w_state_nx = ST_REQ;
        end
        default: w_state_nx = ST_REQ;
      endcase
      // Flush wins over everything above. A request already in flight (WAIT/DISCARD with no
      // response this cycle) must still be drained, so those paths park in DISCARD; a response
      // arriving alongside the flush retires that request and fetch can restart immediately.
      if (bus.flush) begin
        w_pc_nx = bus.flush_pc;
        w_latch = 1'b0;
        w_push  = 1'b0;
        if ((r_state == ST_WAIT || r_state == ST_DISCARD) && !bus.fetch_valid)
          w_state_nx = ST_DISCARD;
        else
          w_state_nx = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_REQ;
      r_pc           <= RESET_PC;
      r_hold_pc      <= '0;
      r_inst         <= '0;
      r_hold_valid   <= 1'b0;
      r_last_taken   <= 1'b0;
      r_last_pred_pc <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      if (w_latch) begin
        r_inst       <= bus.fetch_inst;
        r_hold_pc    <= r_pc;
        r_hold_valid <= 1'b1;
      end else if (w_push || (bus.rdy && bus.flush)) begin
        r_hold_valid <= 1'b0;
      end
      if (bus.rdy && w_in_hold) begin
        r_last_taken   <= w_taken;
        r_last_pred_pc <= w_pred_pc;
      end
    end
  end

  assign bus.fetch_req     = w_fetch_req;
  assign bus.fetch_addr    = r_pc;
  assign bus.bht_id        = r_hold_pc[BHT_IDX_W+1:2];
  assign bus.iq_push       = w_push;
  assign bus.iq_inst       = r_inst;
  assign bus.iq_pc         = r_hold_pc;
  assign bus.iq_pred_taken = w_in_hold ? w_taken : r_last_taken;
  assign bus.iq_pred_pc    = w_in_hold ? w_pred_pc : r_last_pred_pc;
  assign bus.iq_bht_idx    = r_hold_pc[BHT_IDX_W+1:2];
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus a randomized instruction stream checked
// against a next-PC model built from encoded (kind, immediate) pairs.
module tb_fetch_pc_gen;
  localparam int K_ALU = 0, K_B = 1, K_J = 2, K_JALR = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fetch_pc_gen_if #(.ADDR_W(32), .BHT_IDX_W(8)) bus ();
  fetch_pc_gen #(.ADDR_W(32), .BHT_IDX_W(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] word_m [logic [31:0]];
  int          kind_m [logic [31:0]];
  int          imm_m  [logic [31:0]];

  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'd3, 5'd2, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr();
    return {12'h010, 5'd1, 3'b000, 5'd0, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_alu();
    logic [6:0]  ops [6];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111};
    r   = $urandom;
    return {r[31:7], ops[$urandom_range(0, 5)]};
  endfunction

  // Model: branch follows the BHT, JAL always jumps, everything else falls through.
  function automatic logic [31:0] ref_pred(input logic [31:0] pc, input int kind, input int imm,
                                           input logic bht, output logic taken);
    taken = (kind == K_B) ? bht : (kind == K_J);
    return taken ? pc + 32'(imm) : pc + 32'd4;
  endfunction

  task automatic mem_fetch(input logic [31:0] a, output logic [31:0] w, output int k, output int imm);
    int r;
    if (!word_m.exists(a)) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        kind_m[a] = K_B;  imm_m[a] = (int'($urandom_range(0, 2047)) - 1024) * 4;
        word_m[a] = enc_b(imm_m[a]);
      end else if (r == 3) begin
        kind_m[a] = K_J;  imm_m[a] = (int'($urandom_range(0, 262143)) - 131072) * 4;
        word_m[a] = enc_j(imm_m[a]);
      end else if (r == 4) begin
        kind_m[a] = K_JALR; imm_m[a] = 0; word_m[a] = enc_jalr();
      end else begin
        kind_m[a] = K_ALU;  imm_m[a] = 0; word_m[a] = enc_alu();
      end
    end
    w = word_m[a]; k = kind_m[a]; imm = imm_m[a];
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Answers one i-cache request after lat WAIT cycles; returns in HOLD with outputs settled.
  task automatic serve(input logic [31:0] word, input int lat, output logic [31:0] addr);
    bit ok;
    ok   = 1'b0;
    addr = 'x;
    for (int w = 0; w < 20; w++) begin
      settle();
      if (bus.fetch_req === 1'b1) begin ok = 1'b1; break; end
      next();
    end
    if (!ok) return;
    addr = bus.fetch_addr;
    next();
    for (int i = 1; i < lat; i++) next();
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = word;
    next();
    settle();
  endtask

  task automatic hop(input logic [31:0] target);
    logic [31:0] a;
    serve(enc_alu(), 1, a);
    bus.iq_full  = 1'b0;
    bus.flush    = 1'b1;
    bus.flush_pc = target;
    next();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next(); next(); settle();
    n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL rst_fetch_req got=%b exp=0", bus.fetch_req); else n_pass++;
    n_total++; if (bus.iq_push !== 1'b0) $display("FAIL rst_iq_push got=%b exp=0", bus.iq_push); else n_pass++;
    n_total++; if (bus.iq_pred_taken !== 1'b0) $display("FAIL rst_pred_taken got=%b exp=0", bus.iq_pred_taken); else n_pass++;
    rst = 1'b0;
    settle();
    n_total++; if (bus.fetch_req !== 1'b1) $display("FAIL rst_first_req got=%b exp=1", bus.fetch_req); else n_pass++;
    n_total++; if (bus.fetch_addr !== 32'h0) $display("FAIL rst_first_addr got=%h exp=0", bus.fetch_addr); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] a, w, pc;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      w  = enc_alu();
      serve(w, int'($urandom_range(1, 3)), a);
      n_total++; if (a !== pc) $display("FAIL seq_addr got=%h exp=%h", a, pc); else n_pass++;
      bus.bht_get = 1'($urandom_range(0, 1));
      bus.iq_full = 1'b0;
      settle();
      n_total++; if (bus.iq_push !== 1'b1) $display("FAIL seq_push got=%b exp=1", bus.iq_push); else n_pass++;
      n_total++; if (bus.iq_pred_taken !== 1'b0) $display("FAIL seq_taken got=%b exp=0", bus.iq_pred_taken); else n_pass++;
      n_total++; if (bus.iq_pred_pc !== pc + 32'd4) $display("FAIL seq_pred_pc got=%h exp=%h", bus.iq_pred_pc, pc + 32'd4); else n_pass++;
      n_total++; if (bus.iq_pc !== pc) $display("FAIL seq_iq_pc got=%h exp=%h", bus.iq_pc, pc); else n_pass++;
      n_total++; if (bus.iq_inst !== w) $display("FAIL seq_inst got=%h exp=%h", bus.iq_inst, w); else n_pass++;
      next();
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    hop(32'h10);
    serve(enc_b(-8), 2, a);
    n_total++; if (a !== 32'h10) $display("FAIL beq_addr got=%h exp=10", a); else n_pass++;
    bus.bht_get = 1'b1; bus.iq_full = 1'b0; settle();
    n_total++; if (bus.iq_pred_pc !== 32'h8) $display("FAIL beq_t_pred got=%h exp=8", bus.iq_pred_pc); else n_pass++;
    n_total++; if (bus.iq_pred_taken !== 1'b1) $display("FAIL beq_t_taken got=%b exp=1", bus.iq_pred_taken); else n_pass++;
    n_total++; if (bus.iq_bht_idx !== 8'd4) $display("FAIL beq_bht_idx got=%h exp=4", bus.iq_bht_idx); else n_pass++;
    n_total++; if (bus.bht_id !== 8'd4) $display("FAIL beq_bht_id got=%h exp=4", bus.bht_id); else n_pass++;
    bus.bht_get = 1'b0; settle();
    n_total++; if (bus.iq_pred_pc !== 32'h14) $display("FAIL beq_nt_pred got=%h exp=14", bus.iq_pred_pc); else n_pass++;
    n_total++; if (bus.iq_pred_taken !== 1'b0) $display("FAIL beq_nt_taken got=%b exp=0", bus.iq_pred_taken); else n_pass++;
    next();
    serve(enc_alu(), 1, a);
    n_total++; if (a !== 32'h14) $display("FAIL beq_follow got=%h exp=14", a); else n_pass++;
    bus.flush = 1'b1; bus.flush_pc = 32'h20;
    next();
  endtask

  task automatic test_jump();
    logic [31:0] a;
    serve(enc_j(32'h100), 1, a);
    n_total++; if (a !== 32'h20) $display("FAIL jal_addr got=%h exp=20", a); else n_pass++;
    for (int b = 0; b < 2; b++) begin
      bus.bht_get = 1'(b); bus.iq_full = 1'b0; settle();
      n_total++; if (bus.iq_pred_pc !== 32'h120) $display("FAIL jal_pred bht=%0d got=%h exp=120", b, bus.iq_pred_pc); else n_pass++;
      n_total++; if (bus.iq_pred_taken !== 1'b1) $display("FAIL jal_taken bht=%0d got=%b exp=1", b, bus.iq_pred_taken); else n_pass++;
    end
    next();
    serve(enc_jalr(), 3, a);
    n_total++; if (a !== 32'h120) $display("FAIL jalr_addr got=%h exp=120", a); else n_pass++;
    bus.bht_get = 1'b1; settle();
    n_total++; if (bus.iq_pred_pc !== 32'h124) $display("FAIL jalr_pred got=%h exp=124", bus.iq_pred_pc); else n_pass++;
    n_total++; if (bus.iq_pred_taken !== 1'b0) $display("FAIL jalr_taken got=%b exp=0", bus.iq_pred_taken); else n_pass++;
    next();
  endtask

  task automatic test_iq_full();
    logic [31:0] a;
    serve(enc_alu(), 1, a);
    n_total++; if (a !== 32'h124) $display("FAIL full_addr got=%h exp=124", a); else n_pass++;
    bus.iq_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_total++; if (bus.iq_push !== 1'b0) $display("FAIL full_push c=%0d got=%b exp=0", c, bus.iq_push); else n_pass++;
      n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL full_req c=%0d got=%b exp=0", c, bus.fetch_req); else n_pass++;
      n_total++; if (bus.iq_pc !== 32'h124) $display("FAIL full_pc c=%0d got=%h exp=124", c, bus.iq_pc); else n_pass++;
      n_total++; if (bus.iq_pred_pc !== 32'h128) $display("FAIL full_pred c=%0d got=%h exp=128", c, bus.iq_pred_pc); else n_pass++;
      next();
    end
    bus.iq_full = 1'b0; settle();
    n_total++; if (bus.iq_push !== 1'b1) $display("FAIL full_release got=%b exp=1", bus.iq_push); else n_pass++;
    next(); settle();
    n_total++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h128) $display("FAIL full_next req=%b addr=%h exp=1/128", bus.fetch_req, bus.fetch_addr); else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] a;
    next();
    bus.flush = 1'b1; bus.flush_pc = 32'h200; settle();
    n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL fl_wait_req got=%b exp=0", bus.fetch_req); else n_pass++;
    next(); settle();
    n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL fl_disc_req got=%b exp=0", bus.fetch_req); else n_pass++;
    next();
    bus.fetch_valid = 1'b1; bus.fetch_inst = enc_j(64); settle();
    n_total++; if (bus.iq_push !== 1'b0 || bus.fetch_req !== 1'b0) $display("FAIL fl_stale push=%b req=%b exp=0/0", bus.iq_push, bus.fetch_req); else n_pass++;
    next(); settle();
    n_total++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h200) $display("FAIL fl_restart req=%b addr=%h exp=1/200", bus.fetch_req, bus.fetch_addr); else n_pass++;
    serve(enc_alu(), 2, a);
    n_total++; if (a !== 32'h200) $display("FAIL fl_addr got=%h exp=200", a); else n_pass++;
    bus.iq_full = 1'b0; bus.flush = 1'b1; bus.flush_pc = 32'h300; settle();
    n_total++; if (bus.iq_push !== 1'b0) $display("FAIL fl_hold_push got=%b exp=0", bus.iq_push); else n_pass++;
    next(); settle();
    n_total++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h300) $display("FAIL fl_hold_next req=%b addr=%h exp=1/300", bus.fetch_req, bus.fetch_addr); else n_pass++;
  endtask

  task automatic test_rdy();
    logic [31:0] a;
    serve(enc_b(16), 1, a);
    n_total++; if (a !== 32'h300) $display("FAIL rdy_addr got=%h exp=300", a); else n_pass++;
    bus.bht_get = 1'b1; bus.iq_full = 1'b0; bus.rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_total++; if (bus.iq_push !== 1'b0 || bus.fetch_req !== 1'b0) $display("FAIL rdy_frozen c=%0d push=%b req=%b exp=0/0", c, bus.iq_push, bus.fetch_req); else n_pass++;
      n_total++; if (bus.iq_pc !== 32'h300) $display("FAIL rdy_pc c=%0d got=%h exp=300", c, bus.iq_pc); else n_pass++;
      next();
    end
    bus.rdy = 1'b1; settle();
    n_total++; if (bus.iq_push !== 1'b1 || bus.iq_pred_pc !== 32'h310) $display("FAIL rdy_resume push=%b pred=%h exp=1/310", bus.iq_push, bus.iq_pred_pc); else n_pass++;
    next(); settle();
    n_total++; if (bus.fetch_addr !== 32'h310) $display("FAIL rdy_next got=%h exp=310", bus.fetch_addr); else n_pass++;
    next();
    bus.fetch_valid = 1'b1; bus.fetch_inst = enc_alu(); bus.flush = 1'b1; bus.flush_pc = 32'h400;
    next(); settle();
    n_total++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h400) $display("FAIL wait_flush req=%b addr=%h exp=1/400", bus.fetch_req, bus.fetch_addr); else n_pass++;
    next();
    rst = 1'b1;
    next(); settle();
    n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL wait_rst_req got=%b exp=0", bus.fetch_req); else n_pass++;
    rst = 1'b0; settle();
    n_total++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0) $display("FAIL wait_rst_restart req=%b addr=%h exp=1/0", bus.fetch_req, bus.fetch_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    hop(32'hFFFF_FFFC);
    serve(enc_alu(), 1, a);
    n_total++; if (a !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffc", a); else n_pass++;
    bus.iq_full = 1'b0; settle();
    n_total++; if (bus.iq_pred_pc !== 32'h0) $display("FAIL wrap_pred got=%h exp=0", bus.iq_pred_pc); else n_pass++;
    n_total++; if (bus.iq_bht_idx !== 8'hFF) $display("FAIL wrap_idx got=%h exp=ff", bus.iq_bht_idx); else n_pass++;
    next();
    serve(enc_j(-8), 1, a);
    n_total++; if (a !== 32'h0) $display("FAIL wrap_jal_addr got=%h exp=0", a); else n_pass++;
    n_total++; if (bus.iq_pred_pc !== 32'hFFFF_FFF8) $display("FAIL wrap_jal_pred got=%h exp=fffffff8", bus.iq_pred_pc); else n_pass++;
    bus.flush = 1'b1; bus.flush_pc = 32'h1000;
    next();
  endtask

  task automatic test_random_stream();
    logic [31:0] model_pc, a, w, exp_pc, tgt;
    int          k, imm;
    logic        tk, exp_push, fl;
    bit          done;
    model_pc = 32'h1000;
    for (int n = 0; n < 80; n++) begin
      mem_fetch(model_pc, w, k, imm);
      serve(w, int'($urandom_range(1, 3)), a);
      n_total++; if (a !== model_pc) $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, a, model_pc); else n_pass++;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        bus.bht_get = 1'($urandom_range(0, 1));
        bus.iq_full = ($urandom_range(0, 3) == 0);
        bus.rdy     = ($urandom_range(0, 7) != 0);
        fl          = ($urandom_range(0, 19) == 0);
        tgt         = ($urandom_range(0, 1) ? 32'hFFFF_FF00 : 32'h0000_2000) + 32'($urandom_range(0, 63) * 4);
        bus.flush   = fl;
        bus.flush_pc = tgt;
        settle();
        exp_push = bus.rdy && !bus.iq_full && !fl;
        exp_pc   = ref_pred(model_pc, k, imm, bus.bht_get, tk);
        n_total++; if (bus.iq_push !== exp_push) $display("FAIL rnd_push n=%0d got=%b exp=%b", n, bus.iq_push, exp_push); else n_pass++;
        n_total++; if (bus.iq_pred_pc !== exp_pc || bus.iq_pred_taken !== tk) $display("FAIL rnd_pred n=%0d got=%h/%b exp=%h/%b", n, bus.iq_pred_pc, bus.iq_pred_taken, exp_pc, tk); else n_pass++;
        n_total++; if (bus.iq_pc !== model_pc || bus.iq_bht_idx !== model_pc[9:2]) $display("FAIL rnd_pc n=%0d got=%h/%h exp=%h/%h", n, bus.iq_pc, bus.iq_bht_idx, model_pc, model_pc[9:2]); else n_pass++;
        if (bus.rdy && fl) begin
          model_pc = tgt; done = 1'b1;
        end else if (exp_push) begin
          model_pc = exp_pc; done = 1'b1;
        end
        next();
      end
      bus.rdy = 1'b1;
      n_total++; if (!done) $display("FAIL rnd_hold_timeout n=%0d got=stuck exp=push", n); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.fetch_valid = 1'b0; bus.fetch_inst = '0; bus.bht_get = 1'b0;
    bus.iq_full = 1'b0; bus.flush = 1'b0; bus.flush_pc = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_iq_full();
    test_flush();
    test_rdy();
    test_wrap();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
